// File: rtl/adiv5_arb.sv
// Two-requester arbiter in front of a single ADIv5 command/response FIFO pair.
// Define ADIV5_ARB_ERRCHK_EN to enable the sticky protocol-error flag ERR.
module adiv5_arb #(
    parameter int CMD_W     = 35,
    parameter int RESP_W    = 35,
    parameter int TAG_DEPTH = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       R0_REQ,
    input  logic [CMD_W-1:0]           R0_WRDATA,
    input  logic                       R0_WREN,
    output logic                       R0_WRFULL,
    output logic [RESP_W-1:0]          R0_RDDATA,
    input  logic                       R0_RDEN,
    output logic                       R0_RDEMPTY,
    input  logic                       R1_REQ,
    input  logic [CMD_W-1:0]           R1_WRDATA,
    input  logic                       R1_WREN,
    output logic                       R1_WRFULL,
    output logic [RESP_W-1:0]          R1_RDDATA,
    input  logic                       R1_RDEN,
    output logic                       R1_RDEMPTY,
    output logic [CMD_W-1:0]           ADIv5_WRDATA,
    output logic                       ADIv5_WREN,
    input  logic                       ADIv5_WRFULL,
    input  logic [RESP_W-1:0]          ADIv5_RDDATA,
    output logic                       ADIv5_RDEN,
    input  logic                       ADIv5_RDEMPTY,
    output logic [1:0]                 GRANT,
    output logic [$clog2(TAG_DEPTH):0] OUTSTANDING,
    output logic                       ERR
);
    localparam int PTR_W   = $clog2(TAG_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               last_q, last_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic tag_empty, tag_full, head;
    logic wr_accept0, wr_accept1, tag_push, tag_pop;

    assign tag_empty = (count_q == '0);
    assign tag_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign head      = tag_mem_q[rd_ptr_q];

    assign R0_WRFULL  = !grant_q[0] || ADIv5_WRFULL || tag_full;
    assign R1_WRFULL  = !grant_q[1] || ADIv5_WRFULL || tag_full;
    assign wr_accept0 = R0_WREN && !R0_WRFULL;
    assign wr_accept1 = R1_WREN && !R1_WRFULL;
    assign tag_push   = wr_accept0 || wr_accept1;

    assign ADIv5_WREN   = tag_push;
    assign ADIv5_WRDATA = grant_q[1] ? R1_WRDATA : R0_WRDATA;

    // The head tag names the only requester allowed to see the next response.
    assign R0_RDEMPTY = ADIv5_RDEMPTY || tag_empty || head;
    assign R1_RDEMPTY = ADIv5_RDEMPTY || tag_empty || !head;
    assign R0_RDDATA  = ADIv5_RDDATA;
    assign R1_RDDATA  = ADIv5_RDDATA;
    assign tag_pop    = (R0_RDEN && !R0_RDEMPTY) || (R1_RDEN && !R1_RDEMPTY);
    assign ADIv5_RDEN = tag_pop;

    assign GRANT       = grant_q;
    assign OUTSTANDING = count_q;

    // NOTE: every variable gets its default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        burst_d = burst_q;
        if (tag_push && burst_q != BURST_W'(MAX_BURST))
            burst_d = burst_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (R0_REQ && R1_REQ) state_d = last_q ? GNT0 : GNT1;
                else if (R0_REQ)      state_d = GNT0;
                else if (R1_REQ)      state_d = GNT1;
            end
            GNT0: begin
                if (!R0_REQ)                             state_d = R1_REQ ? GNT1 : IDLE;
                else if (burst_q == BURST_W'(MAX_BURST)) begin
                    if (R1_REQ) state_d = GNT1;
                    else        burst_d = '0;
                end
            end
            GNT1: begin
                if (!R1_REQ)                             state_d = R0_REQ ? GNT0 : IDLE;
                else if (burst_q == BURST_W'(MAX_BURST)) begin
                    if (R0_REQ) state_d = GNT0;
                    else        burst_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) burst_d = '0;
        if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
        if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
        unique case (state_d)
            GNT0:    grant_d = 2'b01;
            GNT1:    grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (tag_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (tag_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({tag_push, tag_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            burst_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: tag storage is not reset; entries are only read while count_q marks them valid.
    always_ff @(posedge CLK) begin
        if (tag_push) tag_mem_q[wr_ptr_q] <= grant_q[1];
    end

`ifdef ADIV5_ARB_ERRCHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (R0_WREN & R0_WRFULL) | (R1_WREN & R1_WRFULL)
              | (R0_RDEN & R0_RDEMPTY) | (R1_RDEN & R1_RDEMPTY)
              | ((R0_RDEN | R1_RDEN) & tag_empty);
    end

    always_ff @(posedge CLK) begin
        if (RESET) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_adiv5_arb.sv
// Scoreboard bench for adiv5_arb: directed stimulus, expected commands/responses queued,
// a negedge monitor compares whatever the DUT presents; a small model plays the downstream FIFOs.
`timescale 1ns/1ps
module tb_adiv5_arb;
    localparam int CMD_W  = 35;
    localparam int RESP_W = 35;

`ifdef ADIV5_ARB_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              R0_REQ = 1'b0, R1_REQ = 1'b0;
    logic [CMD_W-1:0]  R0_WRDATA = '0, R1_WRDATA = '0;
    logic              R0_WREN = 1'b0, R1_WREN = 1'b0;
    logic              R0_WRFULL, R1_WRFULL;
    logic [RESP_W-1:0] R0_RDDATA, R1_RDDATA;
    logic              R0_RDEN = 1'b0, R1_RDEN = 1'b0;
    logic              R0_RDEMPTY, R1_RDEMPTY;
    logic [CMD_W-1:0]  ADIv5_WRDATA;
    logic              ADIv5_WREN;
    logic              ADIv5_WRFULL = 1'b0;
    logic [RESP_W-1:0] dn_data = '0;
    logic              ADIv5_RDEN;
    logic              dn_empty = 1'b1;
    logic [1:0]        GRANT;
    logic [3:0]        OUTSTANDING;
    logic              ERR;

    always #5 CLK = ~CLK;

    adiv5_arb dut (
        .CLK(CLK), .RESET(RESET),
        .R0_REQ(R0_REQ), .R0_WRDATA(R0_WRDATA), .R0_WREN(R0_WREN), .R0_WRFULL(R0_WRFULL),
        .R0_RDDATA(R0_RDDATA), .R0_RDEN(R0_RDEN), .R0_RDEMPTY(R0_RDEMPTY),
        .R1_REQ(R1_REQ), .R1_WRDATA(R1_WRDATA), .R1_WREN(R1_WREN), .R1_WRFULL(R1_WRFULL),
        .R1_RDDATA(R1_RDDATA), .R1_RDEN(R1_RDEN), .R1_RDEMPTY(R1_RDEMPTY),
        .ADIv5_WRDATA(ADIv5_WRDATA), .ADIv5_WREN(ADIv5_WREN), .ADIv5_WRFULL(ADIv5_WRFULL),
        .ADIv5_RDDATA(dn_data), .ADIv5_RDEN(ADIv5_RDEN), .ADIv5_RDEMPTY(dn_empty),
        .GRANT(GRANT), .OUTSTANDING(OUTSTANDING), .ERR(ERR)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [CMD_W-1:0]  exp_cmd[$];
    logic [RESP_W-1:0] exp_r0[$];
    logic [RESP_W-1:0] exp_r1[$];
    logic [RESP_W-1:0] dn_q[$];
    logic              dn_wr_ev = 1'b0, dn_rd_ev = 1'b0;
    logic [CMD_W-1:0]  dn_wr_data = '0;

    function automatic logic [RESP_W-1:0] resp_of(input logic [CMD_W-1:0] c);
        return {c[CMD_W-1:3] ^ 32'hC0DE_0000, 3'b010};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, expected no transfer", name, act);
    endtask

    // Monitor: compares every downstream push and every requester pop against the scoreboard.
    always @(negedge CLK) begin
        dn_wr_ev = (ADIv5_WREN === 1'b1);
        dn_rd_ev = (ADIv5_RDEN === 1'b1);
        dn_wr_data = ADIv5_WRDATA;
        if (dn_wr_ev) begin
            if (exp_cmd.size() == 0) unexpected("cmd_push", ADIv5_WRDATA);
            else                     check("cmd_push", ADIv5_WRDATA, exp_cmd.pop_front());
        end
        if (R0_RDEN === 1'b1 && R0_RDEMPTY === 1'b0) begin
            if (exp_r0.size() == 0) unexpected("r0_resp", R0_RDDATA);
            else                    check("r0_resp", R0_RDDATA, exp_r0.pop_front());
        end
        if (R1_RDEN === 1'b1 && R1_RDEMPTY === 1'b0) begin
            if (exp_r1.size() == 0) unexpected("r1_resp", R1_RDDATA);
            else                    check("r1_resp", R1_RDDATA, exp_r1.pop_front());
        end
    end

    // Downstream model: each command yields one response, available the following cycle.
    always @(posedge CLK) begin
        if (RESET) begin
            dn_q.delete();
        end else begin
            if (dn_rd_ev && dn_q.size() > 0) void'(dn_q.pop_front());
            if (dn_wr_ev) dn_q.push_back(resp_of(dn_wr_data));
        end
        dn_empty <= (dn_q.size() == 0);
        dn_data  <= (dn_q.size() == 0) ? '0 : dn_q[0];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        RESET = 1'b1;
        R0_REQ = 1'b0; R1_REQ = 1'b0;
        R0_WREN = 1'b0; R1_WREN = 1'b0;
        R0_RDEN = 1'b0; R1_RDEN = 1'b0;
        tick();
        if (chk) begin
            check("rst_grant", GRANT, 2'b00);
            check("rst_outstanding", OUTSTANDING, 0);
            check("rst_wren", ADIv5_WREN, 0);
            check("rst_rden", ADIv5_RDEN, 0);
            check("rst_r0_wrfull", R0_WRFULL, 1);
            check("rst_r1_wrfull", R1_WRFULL, 1);
            check("rst_r0_rdempty", R0_RDEMPTY, 1);
            check("rst_r1_rdempty", R1_RDEMPTY, 1);
            check("rst_err", ERR, 0);
        end
        exp_cmd.delete();
        exp_r0.delete();
        exp_r1.delete();
        RESET = 1'b0;
    endtask

    task automatic do_write(input int n, input logic [31:0] d, input logic [2:0] k);
        logic [CMD_W-1:0] c;
        c = {d, k};
        exp_cmd.push_back(c);
        if (n == 0) begin
            R0_WRDATA = c; R0_WREN = 1'b1; exp_r0.push_back(resp_of(c));
        end else begin
            R1_WRDATA = c; R1_WREN = 1'b1; exp_r1.push_back(resp_of(c));
        end
        @(negedge CLK);
        check(n == 0 ? "r0_wrfull_at_write" : "r1_wrfull_at_write",
              n == 0 ? R0_WRFULL : R1_WRFULL, 0);
        tick();
        R0_WREN = 1'b0;
        R1_WREN = 1'b0;
    endtask

    task automatic do_pop(input int n);
        if (n == 0) R0_RDEN = 1'b1;
        else        R1_RDEN = 1'b1;
        @(negedge CLK);
        check(n == 0 ? "r0_rdempty_at_pop" : "r1_rdempty_at_pop",
              n == 0 ? R0_RDEMPTY : R1_RDEMPTY, 0);
        tick();
        R0_RDEN = 1'b0;
        R1_RDEN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        do_reset(1'b1);

        // Single requester, three writes.
        R0_REQ = 1'b1;
        #1 check("grant_before_sample", GRANT, 2'b00);
        tick();
        check("grant_r0_alone", GRANT, 2'b01);
        ADIv5_WRFULL = 1'b1;
        #1 check("r0_wrfull_downstream_full", R0_WRFULL, 1);
        ADIv5_WRFULL = 1'b0;
        #1 check("r1_wrfull_not_granted", R1_WRFULL, 1);
        for (int i = 1; i <= 3; i++) do_write(0, 32'h0000_0000 + i, 3'b001);
        check("outstanding_3", OUTSTANDING, 3);
        check("r1_rdempty_head_r0", R1_RDEMPTY, 1);
        for (int i = 0; i < 3; i++) do_pop(0);
        check("outstanding_drained", OUTSTANDING, 0);
        check("cmd_queue_drained", exp_cmd.size(), 0);

        // Simultaneous requests and hand-over on REQ drop; LAST-based fairness.
        do_reset(1'b0);
        R0_REQ = 1'b1; R1_REQ = 1'b1;
        tick();
        check("grant_both_after_reset", GRANT, 2'b01);
        R0_REQ = 1'b0;
        tick();
        check("grant_r0_drop", GRANT, 2'b10);
        do_write(1, 32'h1111_0001, 3'b010);
        do_pop(1);
        R1_REQ = 1'b0;
        R0_REQ = 1'b1;
        tick();
        check("grant_r0_again", GRANT, 2'b01);
        R0_REQ = 1'b0;
        tick();
        check("grant_idle", GRANT, 2'b00);
        R0_REQ = 1'b1; R1_REQ = 1'b1;
        tick();
        check("grant_fair_r1", GRANT, 2'b10);

        // Burst limit forces hand-over; push and pop together keep occupancy flat.
        do_reset(1'b0);
        R0_REQ = 1'b1; R1_REQ = 1'b1;
        tick();
        check("burst_grant_r0", GRANT, 2'b01);
        R0_RDEN = 1'b1;
        for (int i = 1; i <= 16; i++) do_write(0, 32'h0000_0100 + i, 3'b011);
        check("burst_outstanding_flat", OUTSTANDING, 1);
        check("burst_grant_held", GRANT, 2'b01);
        tick();
        R0_RDEN = 1'b0;
        check("burst_handover", GRANT, 2'b10);
        check("burst_outstanding_0", OUTSTANDING, 0);
        do_write(1, 32'h0000_BEEF, 3'b101);
        do_pop(1);
        check("burst_r0_resp_drained", exp_r0.size(), 0);

        // Cross-requester response routing follows acceptance order.
        do_reset(1'b0);
        R0_REQ = 1'b1;
        tick();
        do_write(0, 32'hAAAA_0001, 3'b001);
        R0_REQ = 1'b0; R1_REQ = 1'b1;
        tick();
        check("route_grant_r1", GRANT, 2'b10);
        do_write(1, 32'hBBBB_0002, 3'b001);
        R1_REQ = 1'b0; R0_REQ = 1'b1;
        tick();
        check("route_grant_r0", GRANT, 2'b01);
        do_write(0, 32'hCCCC_0003, 3'b001);
        check("route_outstanding_3", OUTSTANDING, 3);
        check("route_r1_blocked", R1_RDEMPTY, 1);
        check("route_r0_ready", R0_RDEMPTY, 0);
        do_pop(0);
        check("route_r0_blocked", R0_RDEMPTY, 1);
        check("route_r1_ready", R1_RDEMPTY, 0);
        do_pop(1);
        do_pop(0);
        check("route_outstanding_0", OUTSTANDING, 0);
        check("route_no_err", ERR, 0);
        check("route_r0_drained", exp_r0.size(), 0);
        check("route_r1_drained", exp_r1.size(), 0);

        // Tag FIFO full: extra write and non-head pop are ignored.
        do_reset(1'b0);
        R0_REQ = 1'b1;
        tick();
        check("full_err_clear", ERR, 0);
        for (int i = 0; i < 8; i++) do_write(0, 32'h0000_0200 + i, 3'b100);
        check("full_outstanding_8", OUTSTANDING, 8);
        check("full_r0_wrfull", R0_WRFULL, 1);
        check("full_r1_wrfull", R1_WRFULL, 1);
        R0_WRDATA = {32'hDEAD_DEAD, 3'b111};
        R0_WREN = 1'b1;
        tick();
        R0_WREN = 1'b0;
        check("full_drop_outstanding", OUTSTANDING, 8);
        check("full_drop_err", ERR, ERR_EXP);
        R1_RDEN = 1'b1;
        tick();
        R1_RDEN = 1'b0;
        check("nonhead_pop_ignored", OUTSTANDING, 8);
        for (int i = 0; i < 8; i++) do_pop(0);
        check("full_drained", OUTSTANDING, 0);

        // Reset with responses outstanding discards all tags.
        do_reset(1'b0);
        R0_REQ = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) do_write(0, 32'h0000_0300 + i, 3'b110);
        check("pre_reset_outstanding_5", OUTSTANDING, 5);
        do_reset(1'b1);
        tick();
        check("post_reset_outstanding", OUTSTANDING, 0);
        check("post_reset_r0_rdempty", R0_RDEMPTY, 1);
        check("post_reset_r1_rdempty", R1_RDEMPTY, 1);
        check("post_reset_grant", GRANT, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
